// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with two combinational read ports,
// one synchronous write port, optional hardwired-zero register 0, and a
// sequential bulk-clear engine with a busy/done handshake.
// Optional feature macro: REGFILE_BYPASS_EN (write-first forwarding to both
// read ports). Without it, reads return the stored value only.
module regfile_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic              clr_en;
  logic              wr_zero;

  // The write port is blocked for the whole clear so the two never collide.
  assign clr_busy = (state_q != IDLE);
  assign clr_done = (state_q == DONE);
  assign wr_ready = ~clr_busy;
  assign wr_en    = we & wr_ready;
  assign wr_zero  = (ZERO_REG != 0) && (waddr == '0);

  // FSM state and clear counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: one register cleared per CLEAR cycle, counter saturates
  // at the last address; clr_req outside IDLE is simply ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Storage: each register clears on reset or on its clear-engine turn,
  // otherwise takes accepted write data (zero register discards writes).
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else if (clr_en && (cnt_q == ADDR_W'(gi))) begin
          mem_q[gi] <= '0;
        end else if (wr_en && (waddr == ADDR_W'(gi)) && !wr_zero) begin
          mem_q[gi] <= wdata;
        end
      end
    end
  endgenerate

  // Read port A: stored value, optional forwarding, zero register last.
  always_comb begin
    rdata_a = mem_q[raddr_a];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !wr_zero && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
`endif
    if ((ZERO_REG != 0) && (raddr_a == '0)) begin
      rdata_a = '0;
    end
  end

  // Read port B: same selection as port A.
  always_comb begin
    rdata_b = mem_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !wr_zero && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
`endif
    if ((ZERO_REG != 0) && (raddr_b == '0)) begin
      rdata_b = '0;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: scoreboard of expected read data,
// two instances (ZERO_REG=1 and ZERO_REG=0) sharing the same stimulus.
module tb_regfile_param;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic        clr_req;
  logic        wr_ready, clr_busy, clr_done;
  logic [15:0] rdata_a, rdata_b;
  logic        wr_ready_nz, clr_busy_nz, clr_done_nz;
  logic [15:0] rdata_a_nz, rdata_b_nz;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [8];
  logic [31:0] exp_q [$];
  string       tag_q [$];

  regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .wr_ready(wr_ready), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_dut_nz (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .wr_ready(wr_ready_nz), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a_nz), .rdata_b(rdata_b_nz), .clr_req(clr_req),
    .clr_busy(clr_busy_nz), .clr_done(clr_done_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
    if (a != 3'd0) model[a] = d;
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;

    // Reset state.
    #12;
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_clr_done", 32'(clr_done), 32'd0);
    rst = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) begin
      raddr_a = 3'(a); raddr_b = 3'(7 - a);
      sb_push($sformatf("rst_rd_a%0d", a), 32'd0);
      sb_push($sformatf("rst_rd_b%0d", 7 - a), 32'd0);
      #1;
      sb_pop(32'(rdata_a));
      sb_pop(32'(rdata_b));
      tick();
    end

    // Write 0xBEEF to r5; same-cycle read depends on forwarding.
    raddr_a = 3'd5; we = 1'b1; waddr = 3'd5; wdata = 16'hBEEF;
`ifdef REGFILE_BYPASS_EN
    sb_push("wr_same_cycle_r5", 32'h0000BEEF);
`else
    sb_push("wr_same_cycle_r5", 32'(model[5]));
`endif
    #1;
    sb_pop(32'(rdata_a));
    tick();
    we = 1'b0; model[5] = 16'hBEEF;
    sb_push("wr_next_cycle_r5", 32'h0000BEEF);
    #1;
    sb_pop(32'(rdata_a));
    tick();

    // Zero register: discarded when ZERO_REG=1, ordinary when ZERO_REG=0.
    wr(3'd0, 16'h1234);
    raddr_a = 3'd0; raddr_b = 3'd0;
    sb_push("zero_r0_z1", 32'd0);
    sb_push("zero_r0_z0", 32'h00001234);
    #1;
    sb_pop(32'(rdata_a));
    sb_pop(32'(rdata_b_nz));
    tick();

    // Fill r0..r7 and read back.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(32'h1111 * i));
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(i);
      sb_push($sformatf("fill_z1_r%0d", i), 32'(model[i]));
      sb_push($sformatf("fill_z0_r%0d", i), 32'h1111 * i);
      #1;
      sb_pop(32'(rdata_a));
      sb_pop(32'(rdata_b_nz));
      tick();
    end

    // Bulk clear with a blocked write at j=2 and a second request at j=3.
    clr_req = 1'b1;
    tick();  // E0
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int j = 0; j <= 9; j++) begin
      we      = (j == 2);
      waddr   = 3'd3;
      wdata   = 16'hAAAA;
      clr_req = (j == 3);
      raddr_a = 3'd7; raddr_b = 3'd3;
      sb_push($sformatf("clr_r7_j%0d", j), (j < 8) ? 32'h7777 : 32'd0);
      sb_push($sformatf("clr_r3_j%0d", j), (j < 4) ? 32'h3333 : 32'd0);
      #1;
      sb_pop(32'(rdata_a));
      sb_pop(32'(rdata_b));
      check($sformatf("clr_busy_j%0d", j), 32'(clr_busy), 32'(j <= 8));
      check($sformatf("clr_done_j%0d", j), 32'(clr_done), 32'(j == 8));
      check($sformatf("clr_wr_ready_j%0d", j), 32'(wr_ready), 32'(j > 8));
      busy_cnt += int'(clr_busy);
      done_cnt += int'(clr_done);
      tick();
    end
    we = 1'b0; clr_req = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    check("clr_busy_cycles", 32'(busy_cnt), 32'd9);
    check("clr_done_pulses", 32'(done_cnt), 32'd1);
    check("clr_busy_nz_match", 32'(clr_busy_nz), 32'(clr_busy));
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(i);
      sb_push($sformatf("after_clr_z1_r%0d", i), 32'd0);
      sb_push($sformatf("after_clr_z0_r%0d", i), 32'd0);
      #1;
      sb_pop(32'(rdata_a));
      sb_pop(32'(rdata_a_nz));
      check($sformatf("after_clr_done_%0d", i), 32'(clr_done), 32'd0);
      tick();
    end

    // Same-edge write and clear request.
    we = 1'b1; waddr = 3'd2; wdata = 16'h5555; clr_req = 1'b1;
    tick();  // E0
    we = 1'b0; clr_req = 1'b0;
    for (int j = 0; j <= 9; j++) begin
      raddr_a = 3'd2;
      sb_push($sformatf("same_edge_r2_j%0d", j), (j < 3) ? 32'h5555 : 32'd0);
      #1;
      sb_pop(32'(rdata_a));
      check($sformatf("same_edge_busy_j%0d", j), 32'(clr_busy), 32'(j <= 8));
      tick();
    end

    // Reset asserted mid-clear.
    wr(3'd6, 16'h6666);
    clr_req = 1'b1;
    tick();  // E0
    clr_req = 1'b0;
    tick(); tick(); tick();  // after E3, r6 not yet cleared
    raddr_a = 3'd6;
    sb_push("midclr_r6_before_rst", 32'h6666);
    #1;
    sb_pop(32'(rdata_a));
    rst = 1'b1;
    #1;
    sb_push("midclr_r6_in_rst", 32'd0);
    sb_pop(32'(rdata_a));
    check("midclr_rst_busy", 32'(clr_busy), 32'd0);
    check("midclr_rst_done", 32'(clr_done), 32'd0);
    check("midclr_rst_wr_ready", 32'(wr_ready), 32'd1);
    #1;
    rst = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      done_cnt += int'(clr_done);
      busy_cnt += int'(clr_busy);
    end
    check("aborted_clr_done_pulses", 32'(done_cnt), 32'd0);
    check("aborted_clr_busy_cycles", 32'(busy_cnt), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
